// File: rtl/register_file.sv
// register_file: 32 x 32 general-purpose register file for the MIPS datapath.
// Two combinational read ports (A/B) and one synchronous write port.
// Register 0 is hardwired to zero; reset clears every register at once.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding from dataIn onto A/B. Without it a same-cycle read of the
// write target returns the old value until the committing clock edge.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              we,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              writeValid;
  logic [DATA_W-1:0] storedA;
  logic [DATA_W-1:0] storedB;

  assign writeValid = we && (rd != '0);

  // Register storage: asynchronous clear, then write-back of dataIn into rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeValid) begin
      regs[rd] <= dataIn;
    end
  end

  // Raw array reads; register 0 is forced to zero here, not just by storage.
  always_comb begin
    storedA = '0;
    storedB = '0;
    if (rs != '0) storedA = regs[rs];
    if (rt != '0) storedB = regs[rt];
  end

`ifdef REGFILE_BYPASS_EN
  // Output muxes with forwarding: reset first, then a pending write wins.
  always_comb begin
    A = storedA;
    B = storedB;
    if (rst) begin
      A = '0;
      B = '0;
    end else begin
      if (writeValid && (rs == rd)) A = dataIn;
      if (writeValid && (rt == rd)) B = dataIn;
    end
  end
`else
  // Output muxes without forwarding: reset forces zero, otherwise storage.
  always_comb begin
    A = storedA;
    B = storedB;
    if (rst) begin
      A = '0;
      B = '0;
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file.
// Honours REGFILE_BYPASS_EN for the read-during-write expectations.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [31:0] dataIn;
  logic        we;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] A;
  logic [31:0] B;

  int total;
  int bad;

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .dataIn (dataIn),
    .we     (we),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .A      (A),
    .B      (B)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One write through the port, committed on the next rising edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we     = 1'b1;
    rd     = addr;
    dataIn = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    we     = 1'b0;
    rd     = '0;
    rs     = 5'd1;
    rt     = 5'd31;
    dataIn = '0;

    #2;
    checkOutput("reset_A", A, 32'h0);
    checkOutput("reset_B", B, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back writes, then combinational reads.
    applyStimulus(5'd1, 32'd2001);
    applyStimulus(5'd2, 32'd4001);
    applyStimulus(5'd6, 32'd8002);
    applyStimulus(5'd8, 32'd3002);
    rs = 5'd1;
    rt = 5'd2;
    #1;
    checkOutput("b2b_r1", A, 32'd2001);
    checkOutput("b2b_r2", B, 32'd4001);
    rs = 5'd6;
    rt = 5'd8;
    #1;
    checkOutput("b2b_r6", A, 32'd8002);
    checkOutput("b2b_r8", B, 32'd3002);
    rs = 5'd2;
    rt = 5'd2;
    #1;
    checkOutput("same_addr_A", A, 32'd4001);
    checkOutput("same_addr_B", B, 32'd4001);

    // Asynchronous reset mid-cycle, away from any edge.
    rs = 5'd6;
    rt = 5'd8;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_A", A, 32'h0);
    checkOutput("async_rst_B", B, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_r6", A, 32'h0);
    checkOutput("post_rst_r8", B, 32'h0);
    rs = 5'd1;
    rt = 5'd2;
    #1;
    checkOutput("post_rst_r1", A, 32'h0);
    checkOutput("post_rst_r2", B, 32'h0);

    // Register zero ignores writes; r31 holds a full-width pattern.
    applyStimulus(5'd0, 32'hFFFF_FFFF);
    rs = 5'd0;
    rt = 5'd0;
    #1;
    checkOutput("r0_A", A, 32'h0);
    checkOutput("r0_B", B, 32'h0);
    applyStimulus(5'd31, 32'h1234_5678);
    rs = 5'd31;
    rt = 5'd30;
    #1;
    checkOutput("r31", A, 32'h1234_5678);
    checkOutput("r30_untouched", B, 32'h0);

    // Write enable low holds the register over several edges.
    applyStimulus(5'd5, 32'd7);
    @(negedge clk);
    we     = 1'b0;
    rd     = 5'd5;
    dataIn = 32'd99;
    repeat (3) @(posedge clk);
    #1;
    rs = 5'd5;
    #1;
    checkOutput("we_low_r5", A, 32'd7);

    // Read-during-write on both ports.
    applyStimulus(5'd3, 32'd10);
    @(negedge clk);
    rs     = 5'd3;
    rt     = 5'd3;
    we     = 1'b1;
    rd     = 5'd3;
    dataIn = 32'd20;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("rdw_pre_A", A, 32'd20);
    checkOutput("rdw_pre_B", B, 32'd20);
`else
    checkOutput("rdw_pre_A", A, 32'd10);
    checkOutput("rdw_pre_B", B, 32'd10);
`endif
    @(posedge clk);
    #1;
    checkOutput("rdw_post_A", A, 32'd20);
    checkOutput("rdw_post_B", B, 32'd20);
    we = 1'b0;

    // Reset priority over a coincident write across a clock edge.
    applyStimulus(5'd4, 32'd44);
    @(negedge clk);
    rst    = 1'b1;
    we     = 1'b1;
    rd     = 5'd4;
    dataIn = 32'd55;
    rs     = 5'd4;
    #1;
    checkOutput("rst_prio_during", A, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    #1;
    checkOutput("rst_prio_r4", A, 32'h0);

    // Writes resume after reset.
    applyStimulus(5'd4, 32'hCAFE_0004);
    rs = 5'd4;
    rt = 5'd3;
    #1;
    checkOutput("resume_r4", A, 32'hCAFE_0004);
    checkOutput("resume_r3_cleared", B, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the MIPS CPU datapath: 32 registers x 32 bits, two combinational read ports (A/B), one synchronous write port.
- Sits between instruction decode and the ALU.
- rs/rt select the ALU operands; rd/dataIn/we carry write-back.
- Register 0 is hardwired to zero, per MIPS convention.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS = 2**ADDR_W (derived, 32): number of registers. It is a localparam, not overridable.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears every register.
- dataIn  input  DATA_W  write-back data.
- we  input  1  write enable, active-high.
- rs  input  ADDR_W  read address, port A.
- rt  input  ADDR_W  read address, port B.
- rd  input  ADDR_W  write address.
- A  output  DATA_W  contents of register rs.
- B  output  DATA_W  contents of register rt.

Behaviour:
- Storage: NUM_REGS x DATA_W flip-flops, indices 0..NUM_REGS-1.

Reset:
- rst=1 clears all registers to 0 immediately, with no clock needed.
- While rst is held, A=B=0 for any rs/rt.
- rst dominates: a write coincident with rst asserted or deasserting is discarded.
- Normal writes resume on the first rising clk edge with rst=0.

Write:
- On the rising clk edge with rst=0, we=1 and rd!=0: reg[rd] <= dataIn.
- we=0: no register changes.
- Writes to rd=0 are ignored; reg[0] always reads 0.
- Single write port, so there are no write-write conflicts.

Read:
- Purely combinational: A = reg[rs], B = reg[rt]; zero-cycle latency from an address change.
- rs=0 or rt=0 returns 0.
- rs==rt is legal: both ports return the same value.

Read-during-write (macro absent):
- Same-cycle read of rd returns the old value.
- The new value appears on A/B just after the clk edge that commits it.

General:
- No X propagation from unwritten registers after reset: all read 0.
- Outputs carry no registers or pipeline; the design is one always block for storage plus combinational read muxes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: internal write-to-read forwarding.
  - If we=1, rst=0, rd!=0 and rs==rd, then A=dataIn combinationally in the same cycle.
  - Likewise B=dataIn when rt==rd.
  - Register-0 and reset rules still take priority: rd=0 never forwards; rst=1 forces 0.
- Undefined: no forwarding; the read-during-write rule above applies (old value until the edge).

Test Plan:
1. Back-to-back writes, then reads. Stimulus: rst=0, we=1, write 2001->r1, 4001->r2, 8002->r6, 3002->r8 on successive rising edges (10 ns period). Then we=0, rs=1, rt=2 -> A=2001, B=2001+2000=4001. Then rs=6, rt=8 -> A=8002, B=3002, with no clock needed for the reads.
2. Asynchronous reset. With the values from scenario 1 loaded, raise rst mid-cycle with no clk edge -> A=B=0 immediately for rs=6, rt=8. After rst drops, every register still reads 0.
3. Register zero. Write 0xFFFFFFFF with we=1, rd=0 -> rs=0 gives A=0 and rt=0 gives B=0. Write 0x12345678 to r31 -> rs=31 reads 0x12345678.
4. Write enable low. Load r5=7, then we=0, rd=5, dataIn=99 across 3 clock edges -> rs=5 still reads 7.
5. Read-during-write. rs=rt=3, r3=10; drive we=1, rd=3, dataIn=20 before the edge.
   - Macro undefined: A=B=10 until the edge, then 20.
   - REGFILE_BYPASS_EN defined: A=B=20 before the edge.
6. Reset priority. Assert rst together with we=1, rd=4, dataIn=55 across a clk edge -> r4 reads 0 after rst is released.
